tdc_thermo_encoder: RTL and testbench

//  Samples the carry-chain tap bus of the TDC delay line on every clock, removes bubbles,

---
 rtl/tdc_thermo_encoder.sv | 124 ++++++++++++
 tb/tb_tdc_thermo_encoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_thermo_encoder.sv
// tdc_thermo_encoder
//   Samples the TDC carry-chain tap bus every clock, removes single-tap bubbles,
//   detects a new hit on the rising edge of tap 0 and converts the thermometer
//   code into a binary fine time. The fine time is paired with a free-running
//   coarse counter and held in a single-entry valid/ready output register.
//
// Ports
//   clk        sampling clock
//   rst        synchronous active-high reset
//   taps       delay-line CO bus (asynchronous to clk), tap 0 = first stage
//   enable     coarse counter runs and hits are accepted while high
//   ts_valid   output register holds an unread timestamp
//   ts_ready   consumer takes the timestamp when ts_valid & ts_ready
//   ts_fine    number of '1' taps in the corrected code (larger = earlier hit)
//   ts_coarse  coarse count at the edge that first sampled the hit
//   ts_sat     every tap was '1' in the hit sample
//   lost_cnt   hits dropped under back-pressure, saturating at 255
module tdc_thermo_encoder #(
    parameter int NTAPS    = 200,
    parameter int FINE_W   = 8,
    parameter int COARSE_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NTAPS-1:0]    taps,
    input  logic                enable,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [FINE_W-1:0]   ts_fine,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic                ts_sat,
    output logic [7:0]          lost_cnt
);

    logic [COARSE_W-1:0] coarse;
    logic [NTAPS-1:0]    s1, s2, c, c3;
    logic [COARSE_W-1:0] k1, k2, k3, k4;
    logic [1:0]          vld_pipe;
    logic                prev_c0, hit3, hit4, sat4;
    logic [FINE_W-1:0]   fine4, pop;

    // 3-tap majority vote removes isolated bubbles; the end taps have only
    // one neighbour and pass straight through.
    always_comb begin
        c = s2;
        for (int i = 1; i < NTAPS - 1; i++)
            c[i] = (s2[i-1] & s2[i]) | (s2[i] & s2[i+1]) | (s2[i-1] & s2[i+1]);
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NTAPS; i++)
            pop = pop + FINE_W'(c3[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coarse   <= '0;
            s1       <= '0;
            s2       <= '0;
            k1       <= '0;
            k2       <= '0;
            vld_pipe <= '0;
            c3       <= '0;
            hit3     <= 1'b0;
            prev_c0  <= 1'b1;
            k3       <= '0;
            fine4    <= '0;
            sat4     <= 1'b0;
            hit4     <= 1'b0;
            k4       <= '0;
        end else begin
            if (enable)
                coarse <= coarse + 1'b1;

            s1       <= taps;
            k1       <= coarse;
            s2       <= s1;
            k2       <= k1;
            vld_pipe <= {vld_pipe[0], 1'b1};

            // Edge detection only looks at s2 once it holds a real sample:
            // the zeros left in s1/s2 by reset would otherwise look like a
            // falling edge and a line held high through reset would be
            // reported as a hit.
            c3 <= c;
            k3 <= k2;
            if (vld_pipe[1]) begin
                hit3    <= enable & c[0] & ~prev_c0;
                prev_c0 <= c[0];
            end else begin
                hit3    <= 1'b0;
            end

            fine4 <= pop;
            sat4  <= &c3;
            hit4  <= hit3;
            k4    <= k3;
        end
    end

    // Single-entry output register. A held entry is never overwritten: a hit
    // arriving while the consumer stalls is dropped and counted instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_valid  <= 1'b0;
            ts_fine   <= '0;
            ts_coarse <= '0;
            ts_sat    <= 1'b0;
            lost_cnt  <= '0;
        end else if (ts_valid && !ts_ready) begin
            if (hit4 && lost_cnt != 8'hFF)
                lost_cnt <= lost_cnt + 8'd1;
        end else if (hit4) begin
            ts_valid  <= 1'b1;
            ts_fine   <= fine4;
            ts_coarse <= k4;
            ts_sat    <= sat4;
        end else if (ts_ready) begin
            ts_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
module tb_tdc_thermo_encoder;

    localparam int NT = 200;

    logic          clk = 1'b0;
    logic          rst, enable, ts_ready;
    logic [NT-1:0] taps;

    logic          ts_valid, ts_sat;
    logic [7:0]    ts_fine, lost_cnt;
    logic [23:0]   ts_coarse;

    logic          ts_valid4, ts_sat4;
    logic [7:0]    ts_fine4, lost_cnt4;
    logic [3:0]    ts_coarse4;

    int n_chk = 0;
    int n_fail = 0;
    int m = 0;            // expected coarse count

    tdc_thermo_encoder #(.NTAPS(NT), .FINE_W(8), .COARSE_W(24)) dut (
        .clk(clk), .rst(rst), .taps(taps), .enable(enable),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_fine(ts_fine),
        .ts_coarse(ts_coarse), .ts_sat(ts_sat), .lost_cnt(lost_cnt)
    );

    tdc_thermo_encoder #(.NTAPS(NT), .FINE_W(8), .COARSE_W(4)) dut4 (
        .clk(clk), .rst(rst), .taps(taps), .enable(enable),
        .ts_valid(ts_valid4), .ts_ready(ts_ready), .ts_fine(ts_fine4),
        .ts_coarse(ts_coarse4), .ts_sat(ts_sat4), .lost_cnt(lost_cnt4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m <= 0;
        else if (enable) m <= m + 1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_m(input int target);
        for (int i = 0; i < 200 && m != target; i++) cyc(1);
        n_chk++;
        if (m != target) begin
            n_fail++;
            $display("FAIL wait_coarse: got %0d want %0d", m, target);
        end
    endtask

    task automatic test_reset;
        int seen;
        rst = 1'b1; taps = '1; enable = 1'b1; ts_ready = 1'b1;
        cyc(3);
        n_chk++;
        if ({ts_valid, ts_sat, ts_fine, ts_coarse, lost_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b s=%b f=%0d c=%0d l=%0d want all 0",
                     ts_valid, ts_sat, ts_fine, ts_coarse, lost_cnt);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (ts_valid !== 1'b0) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_high_line: got %0d valid cycles want 0", seen);
        end
        n_chk++;
        if (lost_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_lost: got %0d want 0", lost_cnt);
        end
        taps = '0;
        cyc(4);
    endtask

    task automatic test_basic;
        wait_m(100);
        taps = '0; taps[36:0] = '1;
        cyc(4);
        n_chk++;
        if (ts_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: got valid=%b want 0 after 4 edges", ts_valid);
        end
        cyc(1);
        n_chk++;
        if ({ts_valid, ts_fine, ts_coarse, ts_sat} !== {1'b1, 8'd37, 24'd100, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_ts: got v=%b f=%0d c=%0d s=%b want v=1 f=37 c=100 s=0",
                     ts_valid, ts_fine, ts_coarse, ts_sat);
        end
        n_chk++;
        if ({ts_valid4, ts_coarse4} !== {1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL basic_coarse4: got v=%b c=%0d want v=1 c=4", ts_valid4, ts_coarse4);
        end
        taps = '0;
        cyc(1);
        n_chk++;
        if (ts_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_consume: got valid=%b want 0", ts_valid);
        end
        cyc(3);
    endtask

    task automatic test_bubble;
        int e;
        e = m;
        // isolated zero inside the ones and isolated one above the edge
        taps = '0; taps[19:0] = '1; taps[10] = 1'b0; taps[22] = 1'b1;
        cyc(5);
        n_chk++;
        if ({ts_valid, ts_fine, ts_sat} !== {1'b1, 8'd20, 1'b0} || ts_coarse !== 24'(e)) begin
            n_fail++;
            $display("FAIL bubble_ts: got v=%b f=%0d s=%b c=%0d want v=1 f=20 s=0 c=%0d",
                     ts_valid, ts_fine, ts_sat, ts_coarse, e);
        end
        taps = '0;
        cyc(4);
    endtask

    task automatic test_back_to_back;
        int e1;
        ts_ready = 1'b0;
        e1 = m;
        taps = '0; taps[49:0] = '1;
        cyc(1);
        taps = '0;
        cyc(9);
        taps[79:0] = '1;
        cyc(1);
        taps = '0;
        cyc(6);
        n_chk++;
        if ({ts_valid, ts_fine} !== {1'b1, 8'd50} || ts_coarse !== 24'(e1)) begin
            n_fail++;
            $display("FAIL b2b_held: got v=%b f=%0d c=%0d want v=1 f=50 c=%0d",
                     ts_valid, ts_fine, ts_coarse, e1);
        end
        n_chk++;
        if (lost_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL b2b_lost: got %0d want 1", lost_cnt);
        end
        ts_ready = 1'b1;
        cyc(1);
        n_chk++;
        if (ts_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_consume: got valid=%b want 0", ts_valid);
        end
        cyc(2);
    endtask

    task automatic test_saturation;
        int e, nts;
        e = m;
        taps = '1;
        cyc(5);
        n_chk++;
        if ({ts_valid, ts_fine, ts_sat} !== {1'b1, 8'd200, 1'b1} || ts_coarse !== 24'(e)) begin
            n_fail++;
            $display("FAIL sat_ts: got v=%b f=%0d s=%b c=%0d want v=1 f=200 s=1 c=%0d",
                     ts_valid, ts_fine, ts_sat, ts_coarse, e);
        end
        nts = (ts_valid === 1'b1) ? 1 : 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (ts_valid === 1'b1) nts++;
        end
        n_chk++;
        if (nts != 1) begin
            n_fail++;
            $display("FAIL sat_single: got %0d timestamps want 1", nts);
        end
        taps = '0;
        cyc(4);
    endtask

    task automatic test_enable;
        int e0, seen;
        e0 = m;
        enable = 1'b0;
        taps = '0; taps[29:0] = '1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (ts_valid !== 1'b0) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL enable_discard: got %0d valid cycles want 0", seen);
        end
        taps = '0;
        cyc(3);
        enable = 1'b1;
        taps[29:0] = '1;
        cyc(5);
        n_chk++;
        if ({ts_valid, ts_fine} !== {1'b1, 8'd30} || ts_coarse !== 24'(e0)) begin
            n_fail++;
            $display("FAIL enable_hold: got v=%b f=%0d c=%0d want v=1 f=30 c=%0d",
                     ts_valid, ts_fine, ts_coarse, e0);
        end
        n_chk++;
        if (lost_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL enable_lost: got %0d want 1", lost_cnt);
        end
        taps = '0;
        cyc(4);
    endtask

    task automatic test_wrap;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        n_chk++;
        if ({ts_valid, lost_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL wrap_reset: got v=%b l=%0d want v=0 l=0", ts_valid, lost_cnt);
        end
        wait_m(15);
        taps[9:0] = '1;
        cyc(5);
        n_chk++;
        if ({ts_valid4, ts_coarse4, ts_fine4} !== {1'b1, 4'd15, 8'd10} || ts_coarse !== 24'd15) begin
            n_fail++;
            $display("FAIL wrap_pre: got v=%b c4=%0d f=%0d c=%0d want v=1 c4=15 f=10 c=15",
                     ts_valid4, ts_coarse4, ts_fine4, ts_coarse);
        end
        taps = '0;
        wait_m(26);
        taps[9:0] = '1;
        cyc(5);
        n_chk++;
        if ({ts_valid4, ts_coarse4} !== {1'b1, 4'd10} || ts_coarse !== 24'd26) begin
            n_fail++;
            $display("FAIL wrap_post: got v=%b c4=%0d c=%0d want v=1 c4=10 c=26",
                     ts_valid4, ts_coarse4, ts_coarse);
        end
        taps = '0;
        cyc(4);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ts_ready = 1'b0; taps = '0;
        test_reset;
        test_basic;
        test_bubble;
        test_back_to_back;
        test_saturation;
        test_enable;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
